// File: rtl/cmem_arb_pkg.sv
// cmem_arb_pkg
//   Shared types and constants for the command-memory arbiter.
//   - state_t     : access sequencer states
//   - REQ_SPI/CP  : requester identifiers used for owner / last_grant
//   - ADDR_W_DEF / DATA_W_DEF : default register-file geometry
package cmem_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;

  localparam logic REQ_SPI = 1'b0;
  localparam logic REQ_CP  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cmem_arb_pick.sv
// cmem_arb_pick
//   Combinational winner selection between the SPI and CP requesters.
//   Ports:
//     spi_req_i, cp_req_i : raw request levels
//     lock_held_i         : a lock is in force; only owner_i may win
//     owner_i             : current lock owner (REQ_SPI / REQ_CP)
//     last_grant_i        : requester granted most recently (loses ties)
//     grant_valid_o       : some eligible requester is asking
//     grant_id_o          : winner when grant_valid_o=1
module cmem_arb_pick
  import cmem_arb_pkg::*;
(
  input  logic spi_req_i,
  input  logic cp_req_i,
  input  logic lock_held_i,
  input  logic owner_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  logic spi_elig;
  logic cp_elig;

  always_comb begin
    spi_elig      = spi_req_i && (!lock_held_i || owner_i == REQ_SPI);
    cp_elig       = cp_req_i  && (!lock_held_i || owner_i == REQ_CP);
    grant_valid_o = spi_elig || cp_elig;
    if (spi_elig && cp_elig) begin
      grant_id_o = ~last_grant_i;
    end else if (cp_elig) begin
      grant_id_o = REQ_CP;
    end else begin
      grant_id_o = REQ_SPI;
    end
  end

endmodule

// File: rtl/cmem_arbiter.sv
// cmem_arbiter
//   Shares the command-memory register file access port between the SPI
//   command engine and the CP bus interface. Each access is a one-cycle
//   registered strobe followed by a registered response; grants alternate
//   round-robin, and a requester may lock the port across several accesses.
//   Optional feature macro: CMEM_ARB_LOCK_TIMEOUT_EN (forcibly releases a
//   lock whose owner stays idle for LOCK_TIMEOUT cycles, pulsing lock_err).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no access in flight; arbitrate every cycle
//   CMD   | mem_read/mem_write strobe high for this single cycle
//   RESP  | register-file data valid; complete owner, re-arbitrate
//
//   Ports:
//     clk200, reset_n                 : clock, synchronous active-low reset
//     spi_* / cp_*  req/we/lock/addr/wdata in, done/rdata out per requester
//     mem_read/mem_write/mem_addr/mem_wdata : register-file access strobe
//     mem_rdata                       : register-file data (valid in RESP)
//     lock_err                        : forced lock release pulse
module cmem_arbiter
  import cmem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic              clk200,
  input  logic              reset_n,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic              spi_lock,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_done,
  output logic [DATA_W-1:0] spi_rdata,
  input  logic              cp_req,
  input  logic              cp_we,
  input  logic              cp_lock,
  input  logic [ADDR_W-1:0] cp_addr,
  input  logic [DATA_W-1:0] cp_wdata,
  output logic              cp_done,
  output logic [DATA_W-1:0] cp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lock_err
);

  state_t            state_q;
  logic              lock_q;
  logic              owner_q;
  logic              last_grant_q;
  logic              acc_we_q;
  logic              acc_lock_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              spi_done_q;
  logic              cp_done_q;
  logic [DATA_W-1:0] spi_rdata_q;
  logic [DATA_W-1:0] cp_rdata_q;

  logic              pick_lock;
  logic              grant_valid;
  logic              grant_id;
  logic              grant_now;
  logic              timeout_fire;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // In RESP the completing access decides the lock seen by the arbitration
  // at the same edge, so a locked owner can re-request back-to-back.
  always_comb begin
    pick_lock = lock_q && !timeout_fire;
    if (state_q == RESP) begin
      pick_lock = acc_lock_q;
    end
  end

  cmem_arb_pick u_pick (
    .spi_req_i     (spi_req),
    .cp_req_i      (cp_req),
    .lock_held_i   (pick_lock),
    .owner_i       (owner_q),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  assign grant_now = grant_valid && (state_q == IDLE || state_q == RESP);

  assign sel_we    = (grant_id == REQ_CP) ? cp_we    : spi_we;
  assign sel_lock  = (grant_id == REQ_CP) ? cp_lock  : spi_lock;
  assign sel_addr  = (grant_id == REQ_CP) ? cp_addr  : spi_addr;
  assign sel_wdata = (grant_id == REQ_CP) ? cp_wdata : spi_wdata;

  always_ff @(posedge clk200) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      lock_q       <= 1'b0;
      owner_q      <= REQ_SPI;
      last_grant_q <= REQ_SPI;
      acc_we_q     <= 1'b0;
      acc_lock_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      spi_done_q   <= 1'b0;
      cp_done_q    <= 1'b0;
      spi_rdata_q  <= '0;
      cp_rdata_q   <= '0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      spi_done_q  <= 1'b0;
      cp_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (timeout_fire) begin
            lock_q <= 1'b0;
          end
          if (grant_now) begin
            state_q <= CMD;
          end
        end
        CMD: begin
          state_q <= RESP;
        end
        RESP: begin
          lock_q <= acc_lock_q;
          if (owner_q == REQ_CP) begin
            cp_done_q <= 1'b1;
            if (!acc_we_q) begin
              cp_rdata_q <= mem_rdata;
            end
          end else begin
            spi_done_q <= 1'b1;
            if (!acc_we_q) begin
              spi_rdata_q <= mem_rdata;
            end
          end
          state_q <= grant_now ? CMD : IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (grant_now) begin
        owner_q      <= grant_id;
        last_grant_q <= grant_id;
        acc_we_q     <= sel_we;
        acc_lock_q   <= sel_lock;
        mem_addr_q   <= sel_addr;
        mem_wdata_q  <= sel_wdata;
        mem_read_q   <= !sel_we;
        mem_write_q  <= sel_we;
      end
    end
  end

`ifdef CMEM_ARB_LOCK_TIMEOUT_EN
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

  logic [TMO_W-1:0] idle_left_q;
  logic             owner_req;
  logic             idle_cnt_en;
  logic             lock_err_q;

  // Down-counter reloads whenever the owner is not idling on a held lock,
  // which includes every owner grant.
  assign owner_req    = (owner_q == REQ_CP) ? cp_req : spi_req;
  assign idle_cnt_en  = lock_q && (state_q == IDLE) && !owner_req;
  assign timeout_fire = idle_cnt_en && (idle_left_q == TMO_W'(1));

  always_ff @(posedge clk200) begin
    if (!reset_n) begin
      idle_left_q <= TMO_W'(LOCK_TIMEOUT);
      lock_err_q  <= 1'b0;
    end else begin
      lock_err_q <= timeout_fire;
      if (idle_cnt_en && !timeout_fire) begin
        idle_left_q <= idle_left_q - 1'b1;
      end else begin
        idle_left_q <= TMO_W'(LOCK_TIMEOUT);
      end
    end
  end

  assign lock_err = lock_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^LOCK_TIMEOUT;
  assign timeout_fire   = 1'b0;
  assign lock_err       = 1'b0;
`endif

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign spi_done  = spi_done_q;
  assign cp_done   = cp_done_q;
  assign spi_rdata = spi_rdata_q;
  assign cp_rdata  = cp_rdata_q;

endmodule

// File: tb/tb_cmem_arbiter.sv
// tb_cmem_arbiter
//   Self-checking bench for cmem_arbiter: a register-file stand-in, a
//   transaction-level reference model of the port scheduling, a table of
//   single accesses, hand-written multi-cycle sequences, and a randomized
//   two-requester run.
module tb_cmem_arbiter;

  localparam int AW  = 4;
  localparam int DW  = 4;
  localparam int TMO = 8;

  logic clk200 = 1'b0;
  always #5 clk200 = ~clk200;

  logic          reset_n;
  logic          spi_req, spi_we, spi_lock, spi_done;
  logic [AW-1:0] spi_addr;
  logic [DW-1:0] spi_wdata, spi_rdata;
  logic          cp_req, cp_we, cp_lock, cp_done;
  logic [AW-1:0] cp_addr;
  logic [DW-1:0] cp_wdata, cp_rdata;
  logic          mem_read, mem_write, lock_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // bench-driven request fields, index 0 = SPI, 1 = CP
  logic       d_rst;
  logic       d_req[2], d_we[2], d_lock[2];
  logic [3:0] d_addr[2], d_wdata[2];

  assign reset_n   = d_rst;
  assign spi_req   = d_req[0];
  assign spi_we    = d_we[0];
  assign spi_lock  = d_lock[0];
  assign spi_addr  = d_addr[0];
  assign spi_wdata = d_wdata[0];
  assign cp_req    = d_req[1];
  assign cp_we     = d_we[1];
  assign cp_lock   = d_lock[1];
  assign cp_addr   = d_addr[1];
  assign cp_wdata  = d_wdata[1];

  cmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(TMO)) dut (
    .clk200(clk200), .reset_n(reset_n),
    .spi_req(spi_req), .spi_we(spi_we), .spi_lock(spi_lock),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_done(spi_done), .spi_rdata(spi_rdata),
    .cp_req(cp_req), .cp_we(cp_we), .cp_lock(cp_lock),
    .cp_addr(cp_addr), .cp_wdata(cp_wdata),
    .cp_done(cp_done), .cp_rdata(cp_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lock_err(lock_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // register file stand-in and its independent reference copy
  logic [3:0] regs[16];
  logic [3:0] ref_regs[16];

  // ---------------- reference model ----------------
  // The port is either free or has one access in flight that completes two
  // edges after its grant. Arbitration happens at any edge where the port is
  // free, including the completion edge of the previous access.
  logic       s_rst;
  logic       s_req[2], s_we[2], s_lock[2];
  logic [3:0] s_addr[2], s_wdata[2];

  bit         m_busy;
  int         m_left, m_own, m_lock_own, m_last, m_idle, m_grant;
  bit         m_we, m_lk;
  logic [3:0] m_addr, m_wdata;

  bit         e_rd, e_wr, e_sd, e_cd, e_err;
  logic [3:0] e_addr, e_wdata;
  logic [3:0] e_rdat[2];

  task automatic model_reset();
    m_busy = 0; m_left = 0; m_own = 0; m_lock_own = -1; m_last = 0;
    m_idle = 0; m_grant = -1;
    e_rd = 0; e_wr = 0; e_sd = 0; e_cd = 0; e_err = 0;
    e_addr = 4'h0; e_wdata = 4'h0; e_rdat[0] = 4'h0; e_rdat[1] = 4'h0;
  endtask

  task automatic model_edge();
    bit was_idle, el0, el1;
    int w;
    e_rd = 0; e_wr = 0; e_sd = 0; e_cd = 0; e_err = 0; m_grant = -1;
    was_idle = !m_busy;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        if (m_own == 0) e_sd = 1; else e_cd = 1;
        if (!m_we) e_rdat[m_own] = ref_regs[m_addr];
        m_lock_own = m_lk ? m_own : -1;
      end
    end
`ifdef CMEM_ARB_LOCK_TIMEOUT_EN
    if (was_idle && m_lock_own >= 0 && !s_req[m_lock_own]) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_idle = 0; m_lock_own = -1; e_err = 1;
      end
    end else begin
      m_idle = 0;
    end
`else
    if (was_idle) m_idle = 0;
`endif
    if (!m_busy) begin
      el0 = s_req[0] && (m_lock_own != 1);
      el1 = s_req[1] && (m_lock_own != 0);
      if (el0 && el1) w = 1 - m_last;
      else if (el0)   w = 0;
      else if (el1)   w = 1;
      else            w = -1;
      if (w >= 0) begin
        m_grant = w; m_last = w; m_own = w; m_busy = 1; m_left = 2;
        m_we = s_we[w]; m_lk = s_lock[w]; m_addr = s_addr[w]; m_wdata = s_wdata[w];
        e_rd = !m_we; e_wr = m_we; e_addr = m_addr; e_wdata = m_wdata;
        if (m_we) ref_regs[m_addr] = m_wdata;
      end
    end
  endtask

  // one clock: sample inputs, advance model, service register file, compare
  task automatic step();
    logic       pr, pw;
    logic [3:0] pa, pd;
    s_rst = d_rst; s_req = d_req; s_we = d_we; s_lock = d_lock;
    s_addr = d_addr; s_wdata = d_wdata;
    pr = mem_read; pw = mem_write; pa = mem_addr; pd = mem_wdata;
    @(posedge clk200);
    if (!s_rst) model_reset(); else model_edge();
    #1;
    cyc++;
    if (pw) regs[pa] = pd;
    mem_rdata = pr ? regs[pa] : 4'($urandom);
    chk("mem_read", mem_read, e_rd);
    chk("mem_write", mem_write, e_wr);
    if (e_rd || e_wr) chk("mem_addr", mem_addr, e_addr);
    if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
    chk("spi_done", spi_done, e_sd);
    chk("cp_done", cp_done, e_cd);
    chk("spi_rdata", spi_rdata, e_rdat[0]);
    chk("cp_rdata", cp_rdata, e_rdat[1]);
    chk("lock_err", lock_err, e_err);
  endtask

  task automatic set_req(input int r, input logic we, input logic lk,
                         input logic [3:0] a, input logic [3:0] wd);
    d_req[r] = 1'b1; d_we[r] = we; d_lock[r] = lk; d_addr[r] = a; d_wdata[r] = wd;
  endtask

  task automatic do_reset();
    d_req[0] = 0; d_req[1] = 0;
    d_rst = 1'b0;
    step();
    step();
    d_rst = 1'b1;
    chk("rst_outputs", {mem_read, mem_write, mem_addr, mem_wdata, spi_done, cp_done,
                        spi_rdata, cp_rdata, lock_err}, 32'h0);
  endtask

  // ---------------- random-phase drivers ----------------
  int rem[2];
  int gap[2];

  task automatic new_txn(input int r);
    logic lk;
    lk = (rem[r] > 1) ? ($urandom_range(0, 9) < 4) : 1'b0;
    set_req(r, 1'($urandom_range(0, 1)), lk, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
  endtask

  task automatic drive_random();
    for (int r = 0; r < 2; r++) begin
      if (m_grant == r) begin
        rem[r]--;
        if (rem[r] > 0 && $urandom_range(0, 2) == 0) begin
          new_txn(r);
        end else begin
          d_req[r] = 1'b0;
          d_we[r] = 1'($urandom); d_lock[r] = 1'($urandom);
          d_addr[r] = 4'($urandom); d_wdata[r] = 4'($urandom);
          gap[r] = $urandom_range(1, 3);
        end
      end else if (!d_req[r] && rem[r] > 0) begin
        if (gap[r] > 0) gap[r]--;
        if (gap[r] == 0) new_txn(r);
      end
    end
  endtask

  typedef struct {
    logic       who;
    logic       we;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic [3:0] pre;
    logic       exp_rd;
    logic       exp_wr;
    logic       exp_sd;
    logic       exp_cd;
    logic [3:0] exp_srd;
    logic [3:0] exp_crd;
  } vec_t;

  vec_t tv[7];

  initial begin
    int cpg, cp_dones, last_cd, first_sd, cd, le, sst;
    bit drained;

    tv[0] = '{1'b1, 1'b0, 4'h3, 4'h0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'hA};
    tv[1] = '{1'b0, 1'b1, 4'hD, 4'h5, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'hA};
    tv[2] = '{1'b0, 1'b0, 4'hD, 4'h0, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 4'hA};
    tv[3] = '{1'b1, 1'b1, 4'h0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 4'hA};
    tv[4] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 4'hF};
    tv[5] = '{1'b0, 1'b0, 4'h7, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'hF};
    tv[6] = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h9, 1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 4'hF};

    for (int i = 0; i < 16; i++) begin
      regs[i] = 4'(i); ref_regs[i] = 4'(i);
    end
    for (int r = 0; r < 2; r++) begin
      d_req[r] = 0; d_we[r] = 0; d_lock[r] = 0; d_addr[r] = 0; d_wdata[r] = 0;
    end
    d_rst = 1'b0;
    mem_rdata = 4'h0;
    model_reset();
    #2;

    // reset state, then single accesses from the table
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (!tv[i].we) begin
        regs[tv[i].addr] = tv[i].pre; ref_regs[tv[i].addr] = tv[i].pre;
      end
      set_req(int'(tv[i].who), tv[i].we, 1'b0, tv[i].addr, tv[i].wdata);
      step();
      d_req[int'(tv[i].who)] = 1'b0;
      chk("tv_rd", mem_read, tv[i].exp_rd);
      chk("tv_wr", mem_write, tv[i].exp_wr);
      chk("tv_addr", mem_addr, tv[i].addr);
      if (tv[i].we) chk("tv_wdata", mem_wdata, tv[i].wdata);
      step();
      step();
      chk("tv_spi_done", spi_done, tv[i].exp_sd);
      chk("tv_cp_done", cp_done, tv[i].exp_cd);
      chk("tv_spi_rdata", spi_rdata, tv[i].exp_srd);
      chk("tv_cp_rdata", cp_rdata, tv[i].exp_crd);
    end

    // both request continuously: CP first, then strict alternation
    do_reset();
    set_req(0, 1'b0, 1'b0, 4'h1, 4'h0);
    set_req(1, 1'b0, 1'b0, 4'h2, 4'h0);
    step(); step(); step();
    chk("rr_first_cp", cp_done, 1'b1);
    chk("rr_first_spi", spi_done, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_gap", {spi_done, cp_done}, 2'b00);
      step();
      chk("rr_alt", {spi_done, cp_done}, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    d_req[0] = 0; d_req[1] = 0;
    for (int k = 0; k < 4; k++) step();

    // reset during CMD of an SPI write
    do_reset();
    set_req(0, 1'b1, 1'b0, 4'h4, 4'h6);
    step();
    d_req[0] = 1'b0;
    chk("rcmd_write_strobe", mem_write, 1'b1);
    d_rst = 1'b0;
    step();
    chk("rcmd_strobes", {mem_read, mem_write}, 2'b00);
    chk("rcmd_no_done", spi_done, 1'b0);
    d_rst = 1'b1;
    step(); step();
    chk("rcmd_no_done_late", spi_done, 1'b0);
    set_req(0, 1'b0, 1'b0, 4'h4, 4'h0);
    set_req(1, 1'b0, 1'b0, 4'h5, 4'h0);
    step();
    d_req[1] = 1'b0;
    step(); step();
    chk("rcmd_first_cp", {spi_done, cp_done}, 2'b01);
    d_req[0] = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // locked run: six CP reads, SPI requesting throughout
    do_reset();
    set_req(0, 1'b0, 1'b0, 4'h2, 4'h0);
    set_req(1, 1'b0, 1'b1, 4'hA, 4'h0);
    cpg = 0; cp_dones = 0; last_cd = -1; first_sd = -1;
    for (int i = 0; i < 60 && first_sd < 0; i++) begin
      step();
      if (cp_done) begin cp_dones++; last_cd = cyc; end
      if (spi_done) first_sd = cyc;
      if (m_grant == 1) begin
        cpg++;
        if (cpg == 5) d_lock[1] = 1'b0;
        if (cpg == 6) d_req[1] = 1'b0;
      end
      if (m_grant == 0) d_req[0] = 1'b0;
    end
    chk("lock_spi_seen", first_sd >= 0, 1'b1);
    chk("lock_cp_run", cp_dones, 6);
    chk("lock_spi_gap", first_sd - last_cd, 2);

    // idle lock: CP locks and walks away while SPI waits
    do_reset();
    set_req(0, 1'b0, 1'b0, 4'h6, 4'h0);
    set_req(1, 1'b0, 1'b1, 4'h5, 4'h0);
    step();
    d_req[1] = 1'b0;
    cd = -1; le = -1; sst = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cp_done) cd = cyc;
      if (lock_err && le < 0) le = cyc;
      if (mem_read && cd >= 0 && sst < 0) sst = cyc;
      if (m_grant == 0) d_req[0] = 1'b0;
    end
`ifdef CMEM_ARB_LOCK_TIMEOUT_EN
    chk("tmo_err_delay", le - cd, TMO);
    chk("tmo_spi_strobe", sst - le, 0);
`else
    chk("nolock_tmo_err", le, -1);
    chk("nolock_spi_starved", sst, -1);
`endif

    // randomized two-requester traffic against the model
    do_reset();
    rem[0] = 40; rem[1] = 40; gap[0] = 1; gap[1] = 2;
    drained = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rem[0] == 0 && rem[1] == 0 && !m_busy) begin
        drained = 1;
        break;
      end
      step();
      drive_random();
    end
    chk("random_drain", drained, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
